// File: rtl/sram_initiator_pkg.sv
// sram_initiator_pkg: shared states, mask constants and byte-merge helper for SRAM initiators
package sram_initiator_pkg;
  typedef enum logic [1:0] {INIT, IDLE, RD_WAIT, RMW_WR} state_t;
  localparam int DATA_W_DEF = 64;
  localparam int BE_W = DATA_W_DEF / 8;
  localparam logic [BE_W-1:0] BE_ONES = '1;
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b, input logic [7:0] new_b, input logic en);
    return en ? new_b : old_b;
  endfunction
endpackage

// File: rtl/sram_byte_merge.sv
// sram_byte_merge: per-byte select between old and new data under a byte mask
module sram_byte_merge
  import sram_initiator_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0]   i_old,
  input  logic [DATA_W-1:0]   i_new,
  input  logic [DATA_W/8-1:0] i_mask,
  output logic [DATA_W-1:0]   o_merged
);
  for (genvar g = 0; g < DATA_W / 8; g++) begin : g_byte
    assign o_merged[8*g +: 8] = merge_byte(i_old[8*g +: 8], i_new[8*g +: 8], i_mask[g]);
  end
endmodule

// File: rtl/sram_rmw_initiator.sv
// sram_rmw_initiator: valid/ready front end for a maskless 1-cycle-latency SRAM,
// with read-modify-write for partial writes, zero-fill after reset and a buffered read response
module sram_rmw_initiator
  import sram_initiator_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = DATA_W_DEF,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                Clk_CI,
  input  logic                Rst_RI,
  input  logic                ReqValid_SI,
  output logic                ReqReady_SO,
  input  logic                ReqWrite_SI,
  input  logic [ADDR_W-1:0]   ReqAddr_DI,
  input  logic [DATA_W/8-1:0] ReqBEn_DI,
  input  logic [DATA_W-1:0]   ReqWData_DI,
  output logic                RspValid_SO,
  input  logic                RspReady_SI,
  output logic [DATA_W-1:0]   RspRData_DO,
  output logic                InitDone_SO,
  output logic                CSel_SO,
  output logic                WrEn_SO,
  output logic [DATA_W/8-1:0] BEn_SO,
  output logic [ADDR_W-1:0]   Addr_DO,
  output logic [DATA_W-1:0]   WrData_DO,
  input  logic [DATA_W-1:0]   RdData_DI
);
  localparam int BW = DATA_W / 8;
  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, r_addr, w_addr;
  logic [DATA_W-1:0] r_wdata, r_rsp_data, w_merged, w_wdata;
  logic [BW-1:0]     r_ben;
  logic              r_rsp_valid;
  logic              w_ready, w_acc, w_full, w_part, w_cs, w_we;

  sram_byte_merge #(.DATA_W(DATA_W)) u_merge (
    .i_old   (RdData_DI),
    .i_new   (r_wdata),
    .i_mask  (r_ben),
    .o_merged(w_merged)
  );

  always_comb begin
    w_ready     = (r_state == IDLE) && (ReqWrite_SI || !r_rsp_valid || RspReady_SI);
    w_acc       = ReqValid_SI && w_ready;
    w_full      = &ReqBEn_DI;
    w_part      = |ReqBEn_DI && !w_full;
    w_state_nxt = r_state;
    w_cs        = 1'b0;
    w_we        = 1'b0;
    w_addr      = '0;
    w_wdata     = '0;
    case (r_state)
      INIT: begin
        w_cs        = 1'b1;
        w_we        = 1'b1;
        w_addr      = r_cnt;
        w_state_nxt = &r_cnt ? IDLE : INIT;
      end
      IDLE: if (w_acc) begin
        // partial writes only read here; the write half happens in RMW_WR
        w_cs        = !ReqWrite_SI || |ReqBEn_DI;
        w_we        = ReqWrite_SI && w_full;
        w_addr      = w_cs ? ReqAddr_DI : '0;
        w_wdata     = w_we ? ReqWData_DI : '0;
        w_state_nxt = !ReqWrite_SI ? RD_WAIT : w_part ? RMW_WR : IDLE;
      end
      RD_WAIT: w_state_nxt = IDLE;
      RMW_WR: begin
        w_cs        = 1'b1;
        w_we        = 1'b1;
        w_addr      = r_addr;
        w_wdata     = w_merged;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      r_state     <= INIT_ON_RESET ? INIT : IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_ben       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == INIT) ? r_cnt + 1'b1 : r_cnt;
      if (w_acc && ReqWrite_SI && w_part) begin
        r_addr  <= ReqAddr_DI;
        r_wdata <= ReqWData_DI;
        r_ben   <= ReqBEn_DI;
      end
      if (r_state == RD_WAIT) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= RdData_DI;
      end else if (r_rsp_valid && RspReady_SI) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign ReqReady_SO = !Rst_RI && w_ready;
  assign CSel_SO     = !Rst_RI && w_cs;
  assign WrEn_SO     = !Rst_RI && w_we;
  assign BEn_SO      = {BW{WrEn_SO}};
  assign Addr_DO     = Rst_RI ? '0 : w_addr;
  assign WrData_DO   = Rst_RI ? '0 : w_wdata;
  assign RspValid_SO = !Rst_RI && r_rsp_valid;
  assign RspRData_DO = Rst_RI ? '0 : r_rsp_data;
  assign InitDone_SO = !Rst_RI && (r_state != INIT);
endmodule
